// File: rtl/music_pkg.sv
// rtl/music_pkg.sv - shared state codes, end marker and default tempo for the music sequencer
package music_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_LATCH = 2'd2;
    localparam logic [1:0] ST_PLAY  = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        FETCH = ST_FETCH,
        LATCH = ST_LATCH,
        PLAY  = ST_PLAY
    } state_e;

    // A zero note code in the ROM marks the end of the song.
    localparam int END_NOTE = 0;

    // Tempo at 25 MHz, shared with the tone generator's divider table.
    localparam int TICKS_PER_STEP_25M = 4194304;
    localparam int GAP_TICKS_25M      = 262144;

endpackage

// File: rtl/step_timer.sv
// rtl/step_timer.sv - per-step down-counter with load, hold, expire and articulation-gap compare
module step_timer #(
    parameter int TICKS_PER_STEP = 4194304,
    parameter int GAP_TICKS      = 262144
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic run,
    output logic expire,
    output logic gate_open
);

    localparam int TW = (TICKS_PER_STEP > 1) ? $clog2(TICKS_PER_STEP) : 1;
    localparam logic [TW-1:0] LOAD_VAL = TW'(TICKS_PER_STEP - 1);
    // GAP_TICKS must stay below TICKS_PER_STEP or this threshold wraps.
    localparam logic [TW-1:0] OPEN_MAX = TW'(TICKS_PER_STEP - 1 - GAP_TICKS);

    logic [TW-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= LOAD_VAL;
        end else if (run && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign expire    = (count == '0);
    assign gate_open = (count <= OPEN_MAX);

endmodule

// File: rtl/music_sequencer.sv
// rtl/music_sequencer.sv - song playback FSM stepping a registered note ROM at a fixed tempo
module music_sequencer
    import music_pkg::*;
#(
    parameter int ADDR_W         = 8,
    parameter int NOTE_W         = 8,
    parameter int TICKS_PER_STEP = TICKS_PER_STEP_25M,
    parameter int GAP_TICKS      = GAP_TICKS_25M
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic              pause,
    input  logic              loop_en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [NOTE_W-1:0] rom_note,
    output logic [NOTE_W-1:0] note,
    output logic              gate,
    output logic              playing,
    output logic              done
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    state_e state;
    logic   tmr_load;
    logic   tmr_run;
    logic   tmr_expire;
    logic   tmr_open;
    logic   is_end_note;
    logic   step_over;
    logic   end_of_song;
    logic   step_advance;

    assign is_end_note  = (rom_note == NOTE_W'(END_NOTE));
    assign step_over    = (state == PLAY) && !pause && tmr_expire;
    // Running off the last ROM address ends the song just like an end marker.
    assign end_of_song  = ((state == LATCH) && is_end_note) ||
                          (step_over && (rom_addr == LAST_ADDR));
    assign step_advance = step_over && (rom_addr != LAST_ADDR);

    assign tmr_load = (state == LATCH) && !is_end_note;
    assign tmr_run  = (state == PLAY) && !pause;

    step_timer #(
        .TICKS_PER_STEP(TICKS_PER_STEP),
        .GAP_TICKS     (GAP_TICKS)
    ) u_step_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .run      (tmr_run),
        .expire   (tmr_expire),
        .gate_open(tmr_open)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            rom_addr <= '0;
            note     <= '0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (stop) begin
                state    <= IDLE;
                rom_addr <= '0;
                note     <= '0;
            end else begin
                // A natural song end still reports done even if start arrives with it.
                if (end_of_song && !loop_en) begin
                    done <= 1'b1;
                end
                if (start) begin
                    state    <= FETCH;
                    rom_addr <= '0;
                end else if (end_of_song) begin
                    rom_addr <= '0;
                    if (loop_en) begin
                        state <= FETCH;
                    end else begin
                        state <= IDLE;
                        note  <= '0;
                    end
                end else begin
                    case (state)
                        FETCH: state <= LATCH;
                        LATCH: begin
                            note  <= rom_note;
                            state <= PLAY;
                        end
                        PLAY: begin
                            if (step_advance) begin
                                rom_addr <= rom_addr + 1'b1;
                                state    <= FETCH;
                            end
                        end
                        default: state <= state;
                    endcase
                end
            end
        end
    end

    assign playing = (state != IDLE);
    assign gate    = (state == PLAY) && !pause && tmr_open;

endmodule

// File: tb/tb_music_sequencer.sv
// tb/tb_music_sequencer.sv - randomized and directed checks of music_sequencer against a step-level model
module tb_music_sequencer;

    localparam int T = 8;
    localparam int G = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       pause = 1'b0;
    logic       loop_en = 1'b0;
    logic [7:0] rom_addr;
    logic [7:0] rom_note = 8'd0;
    logic [7:0] note;
    logic       gate;
    logic       playing;
    logic       done;

    always #5 clk = ~clk;

    music_sequencer #(
        .ADDR_W(8), .NOTE_W(8), .TICKS_PER_STEP(T), .GAP_TICKS(G)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .pause(pause),
        .loop_en(loop_en), .rom_addr(rom_addr), .rom_note(rom_note),
        .note(note), .gate(gate), .playing(playing), .done(done)
    );

    logic [7:0] mem [256];
    always @(posedge clk) rom_note <= mem[rom_addr];

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: where we are in the song (idle / fetching / latching / sounding),
    // which step, and how many ticks of the sounding step have elapsed.
    int m_phase   = 0;
    int m_addr    = 0;
    int m_note    = 0;
    int m_elapsed = 0;
    bit m_done    = 0;

    always @(posedge clk) begin : model
        bit end_ev;
        end_ev = (m_phase == 2 && mem[m_addr[7:0]] == 8'd0) ||
                 (m_phase == 3 && !pause && m_elapsed == T - 1 && m_addr == 255);
        if (rst) begin
            m_phase = 0; m_addr = 0; m_note = 0; m_elapsed = 0; m_done = 0;
        end else begin
            m_done = 0;
            if (stop) begin
                m_phase = 0; m_addr = 0; m_note = 0;
            end else begin
                if (end_ev && !loop_en) m_done = 1;
                if (start) begin
                    m_phase = 1; m_addr = 0;
                end else if (end_ev) begin
                    m_addr = 0;
                    if (loop_en) m_phase = 1;
                    else begin m_phase = 0; m_note = 0; end
                end else if (m_phase == 1) begin
                    m_phase = 2;
                end else if (m_phase == 2) begin
                    m_note = mem[m_addr[7:0]]; m_elapsed = 0; m_phase = 3;
                end else if (m_phase == 3 && !pause) begin
                    if (m_elapsed == T - 1) begin m_addr++; m_phase = 1; end
                    else m_elapsed++;
                end
            end
        end
    end

    bit chk_en = 0;
    always @(negedge clk) begin
        if (chk_en) begin
            check("playing", {31'd0, playing}, {31'd0, m_phase != 0});
            check("gate", {31'd0, gate}, {31'd0, m_phase == 3 && !pause && m_elapsed >= G});
            check("note", {24'd0, note}, m_note);
            check("done", {31'd0, done}, {31'd0, m_done});
            if (m_phase != 0) check("rom_addr", {24'd0, rom_addr}, m_addr);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    int k;
    int hit;
    int done_cnt;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'd0;
        mem[0] = 8'd25;
        mem[1] = 8'd27;

        repeat (3) tick();
        rst = 1'b0;
        @(negedge clk);
        check("reset_rom_addr", {24'd0, rom_addr}, 0);
        check("reset_note", {24'd0, note}, 0);
        check("reset_gate", {31'd0, gate}, 0);
        check("reset_playing", {31'd0, playing}, 0);
        check("reset_done", {31'd0, done}, 0);
        chk_en = 1;

        // First steps, counted from the cycle after start is sampled.
        tick();
        pulse_start();
        for (k = 1; k <= 13; k++) begin
            @(negedge clk);
            check($sformatf("gate_c%0d", k), {31'd0, gate}, {31'd0, (k >= 5 && k <= 10)});
            if (k == 1)  check("addr_c1", {24'd0, rom_addr}, 0);
            if (k == 3)  check("note_c3", {24'd0, note}, 25);
            if (k == 11) check("addr_c11", {24'd0, rom_addr}, 1);
            if (k == 13) check("note_c13", {24'd0, note}, 27);
            tick();
        end
        hit = -1;
        for (k = 14; k <= 40 && hit < 0; k++) begin
            @(negedge clk);
            if (done) hit = k;
            tick();
        end
        check("end_marker_done_cycle", hit, 23);
        @(negedge clk);
        check("after_done_done", {31'd0, done}, 0);
        check("after_done_playing", {31'd0, playing}, 0);
        check("after_done_note", {24'd0, note}, 0);
        check("after_done_gate", {31'd0, gate}, 0);

        // Looping song never reports done.
        tick();
        loop_en = 1'b1;
        pulse_start();
        done_cnt = 0;
        hit = 0;
        for (k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (done) done_cnt++;
            if (k > 25 && note == 8'd25) hit = 1;
            tick();
        end
        check("loop_done_count", done_cnt, 0);
        check("loop_note25_recurs", hit, 1);
        check("loop_playing", {31'd0, playing}, 1);
        pulse_stop();

        // Five paused cycles stretch the first step by five.
        pulse_start();
        repeat (5) tick();
        pause = 1'b1;
        repeat (2) tick();
        @(negedge clk);
        check("pause_gate", {31'd0, gate}, 0);
        repeat (3) tick();
        pause = 1'b0;
        hit = -1;
        for (k = 11; k <= 40 && hit < 0; k++) begin
            @(negedge clk);
            if (rom_addr == 8'd1) hit = k;
            tick();
        end
        check("pause_step_end_cycle", hit, 16);
        pulse_stop();

        // Stop during LATCH, then start+stop together: stop wins.
        pulse_start();
        tick();
        stop = 1'b1;
        tick();
        @(negedge clk);
        check("stop_latch_playing", {31'd0, playing}, 0);
        tick();
        start = 1'b1;
        stop = 1'b1;
        tick();
        start = 1'b0;
        stop = 1'b0;
        @(negedge clk);
        check("stop_wins_playing", {31'd0, playing}, 0);
        check("stop_wins_gate", {31'd0, gate}, 0);
        check("stop_wins_done", {31'd0, done}, 0);
        check("stop_wins_note", {24'd0, note}, 0);

        // Randomized control on a random short song.
        tick();
        for (int i = 0; i < 16; i++)
            mem[i] = ($urandom_range(0, 5) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
        for (int i = 0; i < 2500; i++) begin
            start = ($urandom_range(0, 59) == 0);
            stop  = ($urandom_range(0, 149) == 0);
            if ($urandom_range(0, 19) == 0) pause = ~pause;
            if ($urandom_range(0, 99) == 0) loop_en = 1'($urandom_range(0, 1));
            tick();
        end
        start = 1'b0;
        pause = 1'b0;
        loop_en = 1'b0;
        pulse_stop();

        // Full ROM with no end marker: wrapping past 255 ends the song.
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom_range(1, 255));
        tick();
        pulse_start();
        hit = -1;
        for (k = 1; k <= 3000 && hit < 0; k++) begin
            @(negedge clk);
            if (done) hit = k;
            tick();
        end
        check("wrap_done_cycle", hit, 2561);
        @(negedge clk);
        check("wrap_after_playing", {31'd0, playing}, 0);

        chk_en = 0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
